// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, op/state encodings and constants for the mul/div unit
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] ITER_LAST  = 5'd31;
    localparam logic [XLEN-1:0]  DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MFHI  = 3'b100,
        OP_MFLO  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between issue/write-back logic and the mul/div unit
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, rd_addr,
        input  busy, done, div_zero, wb_valid, wb_addr, wb_data, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, rd_addr,
        output busy, done, div_zero, wb_valid, wb_addr, wb_data, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - 64-bit accumulator doing one shift-add multiply or restoring divide step per enable
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        if (load) begin
            acc_d = {{XLEN{1'b0}}, a};
            b_d   = b;
        end else if (step) begin
            if (!is_div) begin
                // Upper half accumulates, multiplier bits retire out of the bottom.
                acc_d = {sum, acc_q[XLEN-1:1]};
            end else if (!diff[XLEN+1]) begin
                acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative mul/div with HI/LO and MFHI/MFLO write-back; MULDIV_SIGNED_EN enables MULT/DIV sign handling
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_zero_q, div_zero_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              b_zero_q, b_zero_d;
    logic [XLEN-1:0]   raw_a_q, raw_a_d;
`ifdef MULDIV_SIGNED_EN
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              a_neg, b_neg;
`endif

    op_e               op_in;
    logic              core_load;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] core_acc;
    logic [2*XLEN-1:0] res;

    muldiv_iter_core u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (state_q == ST_RUN),
        .is_div (is_div_q),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (core_acc)
    );

    always_comb begin
        op_in      = op_e'(bus.op);
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        b_zero_d   = b_zero_q;
        raw_a_d    = raw_a_q;
        core_load  = 1'b0;
        a_mag      = bus.rs_data;
        b_mag      = bus.rt_data;
        res        = core_acc;
`ifdef MULDIV_SIGNED_EN
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        a_neg      = op_in[0] & bus.rs_data[XLEN-1];
        b_neg      = op_in[0] & bus.rt_data[XLEN-1];
        if (a_neg) a_mag = -bus.rs_data;
        if (b_neg) b_mag = -bus.rt_data;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (op_in)
                        OP_MFHI, OP_MFLO: begin
                            wb_valid_d = |bus.rd_addr;
                            wb_addr_d  = bus.rd_addr;
                            wb_data_d  = (op_in == OP_MFHI) ? hi_q : lo_q;
                        end
                        OP_MTHI: hi_d = bus.rs_data;
                        OP_MTLO: lo_d = bus.rs_data;
                        default: begin
                            core_load = 1'b1;
                            state_d   = ST_RUN;
                            cnt_d     = '0;
                            is_div_d  = op_in[1];
                            raw_a_d   = bus.rs_data;
                            b_zero_d  = (bus.rt_data == '0);
`ifdef MULDIV_SIGNED_EN
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
`endif
                        end
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ITER_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_SIGNED_EN
                if (is_div_q) begin
                    res[XLEN-1:0]      = neg_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
                    res[2*XLEN-1:XLEN] = rem_neg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
                end else if (neg_q) begin
                    res = -core_acc;
                end
`endif
                {hi_d, lo_d} = res;
                // Divide by zero reports the dividend exactly as issued, not its magnitude.
                if (is_div_q && b_zero_q) begin
                    lo_d       = DIVZERO_LO;
                    hi_d       = raw_a_q;
                    div_zero_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            raw_a_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            b_zero_q   <= b_zero_d;
            raw_a_q    <= raw_a_d;
`ifdef MULDIV_SIGNED_EN
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
